// File: rtl/imm_gen_stage_if.sv
// Handshake/bus interface for imm_gen_stage.
// Optional macro: IMMGEN_ILLEGAL_FLAG_EN adds illegal_out to the output side.
//
// Valid/ready: a transfer happens on a rising clk edge when valid && ready
// are both high. The producer holds valid and payload steady until that
// edge, and valid never waits on ready.
interface imm_gen_stage_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16,
  parameter int TAG_WIDTH   = 16
);

  // Input side (decoder -> stage)
  logic                   in_valid;
  logic                   in_ready;
  logic [INSTR_WIDTH-1:0] instruction;
  logic [3:0]             im_sel;
  logic [TAG_WIDTH-1:0]   tag_in;

  // Output side (stage -> ID/EX register)
  logic                   out_valid;
  logic                   out_ready;
  logic [DATA_WIDTH-1:0]  imm_out;
  logic [TAG_WIDTH-1:0]   tag_out;

`ifdef IMMGEN_ILLEGAL_FLAG_EN
  logic                   illegal_out;

  modport master (
    output in_valid, instruction, im_sel, tag_in, out_ready,
    input  in_ready, out_valid, imm_out, tag_out, illegal_out
  );

  modport slave (
    input  in_valid, instruction, im_sel, tag_in, out_ready,
    output in_ready, out_valid, imm_out, tag_out, illegal_out
  );
`else
  modport master (
    output in_valid, instruction, im_sel, tag_in, out_ready,
    input  in_ready, out_valid, imm_out, tag_out
  );

  modport slave (
    input  in_valid, instruction, im_sel, tag_in, out_ready,
    output in_ready, out_valid, imm_out, tag_out
  );
`endif

endinterface

// File: rtl/imm_gen_stage.sv
// Registered immediate-generation stage with a one-entry skid buffer.
// Extracts and extends the immediate on the input side, then stores only the
// extended value and the tag. in_ready comes straight from a flop, so there
// is no combinational path from out_ready back to in_ready.
// Optional macro: IMMGEN_ILLEGAL_FLAG_EN adds an illegal-select flag that
// travels with each entry.
module imm_gen_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int INSTR_WIDTH = 16,
  parameter int TAG_WIDTH   = 16
) (
  input  logic        clk,
  input  logic        rst,        // asynchronous, active-low
  input  logic        flush,
  imm_gen_stage_if.slave bus,
  output logic [1:0]  dbg_state   // occupancy state for checkers
);

  // Occupancy: nothing held, only the out register held, or out + skid held.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    in_ready_q, in_ready_d;
  logic [DATA_WIDTH-1:0]   out_imm_q, out_imm_d;
  logic [TAG_WIDTH-1:0]    out_tag_q, out_tag_d;
  logic [DATA_WIDTH-1:0]   skid_imm_q, skid_imm_d;
  logic [TAG_WIDTH-1:0]    skid_tag_q, skid_tag_d;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
  logic                    out_ill_q, out_ill_d;
  logic                    skid_ill_q, skid_ill_d;
  logic                    in_illegal;
`endif

  logic                    sign_en;
  logic [3:0]              shamt;
  logic [DATA_WIDTH-1:0]   imm_ext;
  logic                    accept;
  logic                    emit;
  logic                    out_valid;

  // Bits above the widest field are never used by any select.
  logic                    unused_instr_bits;
  assign unused_instr_bits = ^bus.instruction;

  // Field extraction and zero/sign extension of the offered instruction.
  always_comb begin
    sign_en = bus.im_sel[3];
    shamt   = (bus.instruction[4:2] == 3'b000) ? 4'd8 : {1'b0, bus.instruction[4:2]};
    imm_ext = '0;
    case (bus.im_sel[2:0])
      3'b000: imm_ext = {{(DATA_WIDTH-8){sign_en & bus.instruction[7]}},
                         bus.instruction[7:0]};
      3'b001: imm_ext = {{(DATA_WIDTH-4){sign_en & bus.instruction[3]}},
                         bus.instruction[3:0]};
      3'b010: imm_ext = {{(DATA_WIDTH-5){sign_en & bus.instruction[4]}},
                         bus.instruction[4:0]};
      3'b011: imm_ext = {{(DATA_WIDTH-11){sign_en & bus.instruction[10]}},
                         bus.instruction[10:0]};
      3'b100: imm_ext = {{(DATA_WIDTH-3){sign_en & bus.instruction[4]}},
                         bus.instruction[4:2]};
      // Shift amount: always zero-extended, 0 encodes 8.
      3'b101: imm_ext = {{(DATA_WIDTH-4){1'b0}}, shamt};
      default: imm_ext = '0;
    endcase
  end

`ifdef IMMGEN_ILLEGAL_FLAG_EN
  // Unused select codes, plus a sign-extended shift amount, are flagged.
  always_comb begin
    in_illegal = (bus.im_sel[2:1] == 2'b11) || (bus.im_sel == 4'b1101);
  end
`endif

  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = bus.in_valid && in_ready_q;
  assign emit      = out_valid && bus.out_ready;

  // Next occupancy and datapath moves; flush wins over accept and emit.
  always_comb begin
    state_d    = state_q;
    out_imm_d  = out_imm_q;
    out_tag_d  = out_tag_q;
    skid_imm_d = skid_imm_q;
    skid_tag_d = skid_tag_q;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
    out_ill_d  = out_ill_q;
    skid_ill_d = skid_ill_q;
`endif
    if (flush) begin
      state_d = ST_EMPTY;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
      out_ill_d  = 1'b0;
      skid_ill_d = 1'b0;
`endif
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            out_imm_d = imm_ext;
            out_tag_d = bus.tag_in;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
            out_ill_d = in_illegal;
`endif
            state_d   = ST_ONE;
          end
        end
        ST_ONE: begin
          if (accept && emit) begin
            // Back-to-back: new entry replaces the one leaving.
            out_imm_d = imm_ext;
            out_tag_d = bus.tag_in;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
            out_ill_d = in_illegal;
`endif
          end else if (emit) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            // Out is stalled: park the new entry in the skid register.
            skid_imm_d = imm_ext;
            skid_tag_d = bus.tag_in;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
            skid_ill_d = in_illegal;
`endif
            state_d    = ST_FULL;
          end
        end
        ST_FULL: begin
          // in_ready is low here, so only the skid-to-out move can happen.
          if (emit) begin
            out_imm_d = skid_imm_q;
            out_tag_d = skid_tag_q;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
            out_ill_d = skid_ill_q;
`endif
            state_d   = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
    in_ready_d = (state_d != ST_FULL);
  end

  // State and storage registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      out_imm_q  <= '0;
      out_tag_q  <= '0;
      skid_imm_q <= '0;
      skid_tag_q <= '0;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
      out_ill_q  <= 1'b0;
      skid_ill_q <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      out_imm_q  <= out_imm_d;
      out_tag_q  <= out_tag_d;
      skid_imm_q <= skid_imm_d;
      skid_tag_q <= skid_tag_d;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
      out_ill_q  <= out_ill_d;
      skid_ill_q <= skid_ill_d;
`endif
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid;
  assign bus.imm_out   = out_imm_q;
  assign bus.tag_out   = out_tag_q;
`ifdef IMMGEN_ILLEGAL_FLAG_EN
  assign bus.illegal_out = out_ill_q & out_valid;
`endif
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Bench for imm_gen_stage: directed vector table, back-pressure, flush and
// reset sequences, then randomized traffic against a FIFO reference model.
module tb_imm_gen_stage;

  localparam int DW = 16;
  localparam int IW = 16;
  localparam int TW = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  imm_gen_stage_if #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .TAG_WIDTH(TW)) bus();

  imm_gen_stage #(.DATA_WIDTH(DW), .INSTR_WIDTH(IW), .TAG_WIDTH(TW)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [32:0] exp_q[$];     // {illegal, tag, imm}, front = entry on the output
  logic [15:0] out_log[$];   // tags seen leaving the stage

  typedef struct {
    logic [15:0] instr;
    logic [3:0]  sel;
    logic [15:0] exp_imm;
    logic        exp_ill;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: pick field by position/width, then reinterpret as signed.
  function automatic logic [15:0] ref_imm(input logic [15:0] ins, input logic [3:0] sel);
    int lo, w, val;
    lo = 0;
    w  = 0;
    case (sel[2:0])
      3'd0: begin lo = 0; w = 8;  end
      3'd1: begin lo = 0; w = 4;  end
      3'd2: begin lo = 0; w = 5;  end
      3'd3: begin lo = 0; w = 11; end
      3'd4, 3'd5: begin lo = 2; w = 3; end
      default: return 16'h0000;
    endcase
    val = (int'(ins) >> lo) % (1 << w);
    if (sel[2:0] == 3'd5) return (val == 0) ? 16'd8 : 16'(val);
    if (sel[3] && val >= (1 << (w - 1))) val = val - (1 << w);
    return 16'(val);
  endfunction

  function automatic logic ref_ill(input logic [3:0] sel);
    return (sel[2:1] == 2'b11) || (sel == 4'b1101);
  endfunction

  task automatic check_outputs();
    chk("out_valid", bus.out_valid, exp_q.size() > 0);
    chk("in_ready", bus.in_ready, exp_q.size() < 2);
    if (exp_q.size() > 0) begin
      chk("imm_out", bus.imm_out, exp_q[0][15:0]);
      chk("tag_out", bus.tag_out, exp_q[0][31:16]);
`ifdef IMMGEN_ILLEGAL_FLAG_EN
      chk("illegal_out", bus.illegal_out, exp_q[0][32]);
    end else begin
      chk("illegal_out_idle", bus.illegal_out, 1'b0);
`endif
    end
  endtask

  // ---------------- driver ----------------
  // Called at posedge+1: drive, check, advance one edge, update the model.
  task automatic drive_cycle(input logic v, input logic [15:0] instr, input logic [3:0] sel,
                             input logic [15:0] tag, input logic ordy, input logic fl);
    logic        acc, emt;
    logic [32:0] ent;
    bus.in_valid    = v;
    bus.instruction = instr;
    bus.im_sel      = sel;
    bus.tag_in      = tag;
    bus.out_ready   = ordy;
    flush           = fl;
    #1;
    check_outputs();
    acc = v && (exp_q.size() < 2);
    emt = (exp_q.size() > 0) && ordy;
    ent = {ref_ill(sel), tag, ref_imm(instr, sel)};
    @(posedge clk);
    if (fl) begin
      exp_q.delete();
    end else begin
      if (emt) begin
        out_log.push_back(exp_q[0][31:16]);
        void'(exp_q.pop_front());
      end
      if (acc) exp_q.push_back(ent);
    end
    #1;
  endtask

  task automatic idle_cycle();
    drive_cycle(1'b0, 16'h0, 4'h0, 16'h0, 1'b1, 1'b0);
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int next_tag;
    logic ordy;
    logic rdy_before;

    vecs[0]  = '{16'h00F0, 4'b1000, 16'hFFF0, 1'b0};
    vecs[1]  = '{16'h00F0, 4'b0000, 16'h00F0, 1'b0};
    vecs[2]  = '{16'h0400, 4'b1011, 16'hFC00, 1'b0};
    vecs[3]  = '{16'h0000, 4'b0101, 16'h0008, 1'b0};
    vecs[4]  = '{16'h000C, 4'b0101, 16'h0003, 1'b0};
    vecs[5]  = '{16'h0010, 4'b1100, 16'hFFFC, 1'b0};
    vecs[6]  = '{16'h1234, 4'b0110, 16'h0000, 1'b1};
    vecs[7]  = '{16'h0010, 4'b1101, 16'h0004, 1'b1};
    vecs[8]  = '{16'hFFFF, 4'b0001, 16'h000F, 1'b0};
    vecs[9]  = '{16'h001F, 4'b1010, 16'hFFFF, 1'b0};
    vecs[10] = '{16'h0007, 4'b1001, 16'h0007, 1'b0};
    vecs[11] = '{16'hABCD, 4'b1111, 16'h0000, 1'b1};

    bus.in_valid    = 1'b0;
    bus.instruction = '0;
    bus.im_sel      = '0;
    bus.tag_in      = '0;
    bus.out_ready   = 1'b0;

    // Power-on reset state.
    #12;
    chk("reset_out_valid", bus.out_valid, 1'b0);
    chk("reset_in_ready", bus.in_ready, 1'b1);
    chk("reset_imm_out", bus.imm_out, 16'h0);
    chk("reset_tag_out", bus.tag_out, 16'h0);
`ifdef IMMGEN_ILLEGAL_FLAG_EN
    chk("reset_illegal_out", bus.illegal_out, 1'b0);
`endif
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Directed vectors: accept, check one cycle later, then drain.
    for (int i = 0; i < 12; i++) begin
      drive_cycle(1'b1, vecs[i].instr, vecs[i].sel, 16'(i + 16'h100), 1'b1, 1'b0);
      chk($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
      chk($sformatf("vec%0d_imm", i), bus.imm_out, vecs[i].exp_imm);
`ifdef IMMGEN_ILLEGAL_FLAG_EN
      chk($sformatf("vec%0d_ill", i), bus.illegal_out, vecs[i].exp_ill);
`endif
      idle_cycle();
    end

    // Back-pressure: tags 1..4, out_ready low around the first accept.
    out_log.delete();
    next_tag = 1;
    for (int c = 0; c < 20 && (next_tag <= 4 || exp_q.size() > 0); c++) begin
      ordy       = (c > 2);
      rdy_before = (exp_q.size() < 2);
      if (c == 2) chk("bp_in_ready_low", bus.in_ready, 1'b0);
      drive_cycle(next_tag <= 4, 16'($urandom), 4'($urandom_range(0, 15)),
                  16'(next_tag), ordy, 1'b0);
      if (next_tag <= 4 && rdy_before) next_tag++;
    end
    chk("bp_drained", exp_q.size(), 0);
    chk("bp_count", out_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < out_log.size()) chk($sformatf("bp_order%0d", i), out_log[i], 16'(i + 1));
    end

    // Flush with both registers full and an entry offered.
    drive_cycle(1'b1, 16'h00F0, 4'b1000, 16'h00A1, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h0400, 4'b1011, 16'h00A2, 1'b0, 1'b0);
    chk("pre_flush_in_ready", bus.in_ready, 1'b0);
    out_log.delete();
    drive_cycle(1'b1, 16'h1111, 4'b0000, 16'h0099, 1'b1, 1'b1);
    chk("flush_out_valid", bus.out_valid, 1'b0);
    chk("flush_in_ready", bus.in_ready, 1'b1);
    repeat (3) idle_cycle();
    chk("flush_no_output", out_log.size(), 0);

    // Reset mid-operation with both entries held.
    drive_cycle(1'b1, 16'h00F0, 4'b0000, 16'h00B1, 1'b0, 1'b0);
    drive_cycle(1'b1, 16'h00F0, 4'b0000, 16'h00B2, 1'b0, 1'b0);
    bus.in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", bus.out_valid, 1'b0);
    chk("midrst_in_ready", bus.in_ready, 1'b1);
    chk("midrst_imm_out", bus.imm_out, 16'h0);
    chk("midrst_tag_out", bus.tag_out, 16'h0);
    exp_q.delete();
    #3;
    rst = 1'b1;
    @(posedge clk);
    #1;
    idle_cycle();

    // Randomized traffic against the FIFO model.
    for (int n = 0; n < 400; n++) begin
      drive_cycle($urandom_range(0, 3) != 0, 16'($urandom), 4'($urandom_range(0, 15)),
                  16'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    end
    repeat (3) idle_cycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
- Registered immediate-generation stage between the instruction decoder and the ID/EX register of the 16-bit pipelined CPU.
- Extracts an immediate field from the instruction word and zero- or sign-extends it to DATA_WIDTH.
- Carries a TAG (PC) alongside the immediate.
- Uses a valid/ready handshake with a one-entry skid buffer, so the stage can absorb a back-pressure cycle from the hazard unit without combinational ready paths.

Parameters:
- DATA_WIDTH, 16, width of extended immediate; must be >= 16.
- INSTR_WIDTH, 16, instruction word width; must be >= 11.
- TAG_WIDTH, 16, width of passthrough tag (PC).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- flush  input  1  synchronous pipeline flush; discards all held entries.
- in_valid  input  1  upstream entry present.
- in_ready  output  1  stage can accept this cycle.
- instruction  input  INSTR_WIDTH  instruction word.
- im_sel  input  4  bit3 = 1 sign-extend, 0 zero-extend; [2:0] = field select.
- tag_in  input  TAG_WIDTH  passthrough tag.
- out_valid  output  1  output entry present.
- out_ready  input  1  downstream accepts.
- imm_out  output  DATA_WIDTH  extended immediate.
- tag_out  output  TAG_WIDTH  tag of the entry on imm_out.

Behaviour:
- Field select (im_sel[2:0]):
  - 000: instruction[7:0]
  - 001: [3:0]
  - 010: [4:0]
  - 011: [10:0]
  - 100: [4:2]
  - 101: [4:2] with value 0 mapped to 8 (shift amount). Result is always zero-extended; im_sel[3] is ignored for 101.
  - 110, 111: illegal; imm = 0.
- Extension: the sign bit is the MSB of the selected field. Replicate it to DATA_WIDTH when im_sel[3] = 1; fill with zeros otherwise.
- Extension is computed combinationally on the input side and captured on accept. Storage holds only the extended value and the tag.
- Accept: in_valid && in_ready at a rising edge. Emit: out_valid && out_ready at a rising edge.
- Storage: main register (out) plus skid register (skid).
  - in_ready = !skid_valid, registered; no combinational path from out_ready.
  - Out empty, or out emitting this cycle: accepted entry goes to out. If skid is full, skid moves to out first and the new entry goes to skid.
  - Out full and not emitting: accepted entry goes to skid; in_ready drops next cycle.
  - Skid full and out emitting: skid moves to out; in_ready rises next cycle.
- Latency: 1 cycle from accept to out_valid when the stage is empty. Sustained throughput is 1 entry/cycle while out_ready = 1.
- Ordering: strict FIFO order; the skid entry always emits after the out entry.
- imm_out and tag_out are stable while out_valid && !out_ready.
- Flush:
  - Next edge: out_valid = 0, skid_valid = 0, in_ready = 1.
  - An entry offered in the flush cycle is dropped.
  - Flush has priority over accept and emit.
- Reset (async assert, sync-safe deassert): out_valid = 0, in_ready = 1, imm_out = 0, tag_out = 0, skid cleared. Reset mid-transfer discards all entries.
- Simultaneous flush + out_ready: the entry is not counted as emitted (downstream ignores it under flush).

Optional Feature:
IMMGEN_ILLEGAL_FLAG_EN:
- Defined:
  - Adds output illegal_out (1 bit), captured with each entry. It is 1 when im_sel[2:0] is 110 or 111, or when im_sel = 4'b1101.
  - It travels with the entry through the skid path and reads 0 when out_valid = 0.
  - Reset and flush clear it.
- Undefined: port absent. Illegal selects produce imm = 0, and 1101 behaves as 0101, silently.

Test Plan:
- Reset mid-operation: assert rst with both entries held -> out_valid = 0 immediately, in_ready = 1, imm_out = 0.
- Extension, im_sel = 4'b1000, instruction = 16'h00F0 -> imm_out = 16'hFFF0 one cycle after accept. im_sel = 4'b0000, same instruction -> 16'h00F0. im_sel = 4'b1011, instruction = 16'h0400 -> 16'hFC00.
- Shift amount, im_sel = 4'b0101, instruction[4:2] = 000 -> imm_out = 16'h0008. instruction[4:2] = 011 -> 16'h0003. im_sel = 4'b1100, instruction[4:2] = 100 -> 16'hFFFC.
- Back-pressure: stream 4 entries (tags 1..4) with out_ready low for 2 cycles after the first accept:
  - in_ready drops after the skid fills.
  - Output tag order is 1, 2, 3, 4 with no loss or duplication.
  - Each held imm_out is stable while stalled.
- Flush with both registers full and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1, offered entry absent from output.
- Illegal select im_sel = 4'b0110 -> imm_out = 0; with IMMGEN_ILLEGAL_FLAG_EN, illegal_out = 1 for that entry only. im_sel = 4'b1101 -> illegal_out = 1.
